fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that sequences reads of the 16-entry program memory and hands instructions to the execute stage over a valid/ready handshake. It adds start, jump redirect, halt-on-`0xFFFF` and halted-resume around the storage, keeping the memory itself a plain synchronous-read array. It sits between the program memory and the decode/execute datapath and owns the program counter.

## Interface
- `ADDR_W`, 4, program-memory address width; the PC wraps modulo 2^ADDR_W.
- `DATA_W`, 16, instruction width.
- `HALT_WORD`, 16'hFFFF, encoding that stops fetch.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: pulse; begin or resume fetching (IDLE/HALTED only).
- `jump_valid` in 1: redirect request.
- `jump_addr` in ADDR_W: redirect target.
- `pmem_en` out 1: read strobe to program memory.
- `pmem_addr` out ADDR_W: read address, equals `pc`.
- `pmem_rdata` in DATA_W: memory data, valid one cycle after `pmem_en`.
- `instr` out DATA_W: fetched instruction (registered).
- `instr_valid` out 1: `instr` is valid.
- `instr_ready` in 1: consumer accepts `instr`.
- `pc` out ADDR_W: address of the current or next fetch.
- `halted` out 1: high while in HALTED.
- `busy` out 1: high in ISSUE, READ or HOLD.
- `step` in 1: present only with `SINGLE_STEP_EN`.

## Operation
- **Reset:** when `rst`=0 at a clock edge, state returns to IDLE from any state. All outputs are 0: `pc`, `instr`, `instr_valid`, `pmem_en`, `halted`, `busy`.
- **States:** IDLE, ISSUE, READ, HOLD, HALTED.
- **IDLE:**
  - `jump_valid` loads `pc`←`jump_addr`.
  - `start` moves to ISSUE.
  - If both are high in the same cycle, `start` fetches from `jump_addr`.
- **ISSUE:** `pmem_en`=1, `pmem_addr`=`pc`; move to READ.
- **READ:**
  - If `pmem_rdata`==HALT_WORD: go to HALTED. `instr_valid` stays 0 and the halt word is never emitted.
  - Otherwise: `instr`←`pmem_rdata`, `instr_valid`←1, go to HOLD.
- **HOLD:**
  - `instr` and `instr_valid` are held stable until `instr_ready`=1.
  - On the handshake: `instr_valid`←0, go to ISSUE, and `pc` updates:
    - to `jump_addr` if `jump_valid`=1;
    - else to `pc`+1, wrapping from 2^ADDR_W−1 to 0.
  - `jump_valid` without `instr_ready` in HOLD is ignored.
- **HALTED:**
  - `halted`=1 and `pc` holds the address of the halt word.
  - `jump_valid` loads `pc`←`jump_addr`.
  - `start` moves to ISSUE. Without a same-cycle jump, `pc` first becomes `pc`+1 so fetch resumes after the halt word.
- **Ignored inputs:** `start` is ignored in ISSUE, READ and HOLD. `jump_valid` is ignored in ISSUE and READ.

## Timing
- Latency: `start` sampled at edge N; `pmem_en` high in cycle N+1; `instr_valid` high from cycle N+3.
- Throughput with `instr_ready` tied high: one instruction per 3 cycles.
- `instr_valid` never drops without a handshake, except on reset.
- `halted` asserts the cycle after READ sees HALT_WORD.
- `pmem_en` is high for exactly one cycle per fetch.

## Configuration
- **`SINGLE_STEP_EN` defined:**
  - Adds the `step` input.
  - After each HOLD handshake the FSM waits in ISSUE with `pmem_en`=0 until `step`=1, then issues.
  - `start` from IDLE also requires the next `step` pulse before the first issue.
- **`SINGLE_STEP_EN` undefined:** no `step` port; behaviour is exactly as above.

## Structure
- Shared package `tmvp_pkg` holds:
  - `HALT_WORD`;
  - the state encoding constants `FS_IDLE`, `FS_ISSUE`, `FS_READ`, `FS_HOLD`, `FS_HALTED` (3 bits);
  - default `ADDR_W` and `DATA_W`.
- No sub-module; the memory is external and instantiated alongside as `pmem_rom`.

## Test plan
- Reset with memory {0x1111, 0x2222, 0xFFFF}, `instr_ready`=1, pulse `start`:
  - 0x1111 then 0x2222 emitted with `instr_valid` 3 cycles apart;
  - then `halted`=1 with `pc`=2;
  - 0xFFFF is never valid.
- Hold `instr_ready`=0 for 5 cycles in HOLD: `instr` and `instr_valid` are stable; `pmem_en` stays 0.
- On the handshake of the instruction at `pc`=1, drive `jump_valid`=1, `jump_addr`=9: next `pmem_addr`=9.
- Fill memory with no halt word, run 17 fetches: the PC wraps 15→0 and the 17th instruction equals `pmem[0]`.
- In HALTED at `pc`=2:
  - `start` alone resumes at `pc`=3;
  - `start` with `jump_valid`, `jump_addr`=0 resumes at 0.
- Drop `rst` during HOLD: the next cycle shows `instr_valid`=0, `pc`=0, state IDLE; a later `start` fetches address 0.

Source files
------------

// File: rtl/tmvp_pkg.sv
// Shared constants for the fetch front end:
// halt encoding, FSM state codes and default widths.
package tmvp_pkg;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_DATA_W = 16;

  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  localparam logic [2:0] FS_IDLE   = 3'd0;
  localparam logic [2:0] FS_ISSUE  = 3'd1;
  localparam logic [2:0] FS_READ   = 3'd2;
  localparam logic [2:0] FS_HOLD   = 3'd3;
  localparam logic [2:0] FS_HALTED = 3'd4;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch FSM: owns the PC, reads program memory, hands off over valid/ready.
// Optional SINGLE_STEP_EN gates every issue on the step input.
module fetch_sequencer
  import tmvp_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0] HALT_WORD = tmvp_pkg::HALT_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              pmem_en,
  output logic [ADDR_W-1:0] pmem_addr,
  input  logic [DATA_W-1:0] pmem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              busy
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              go;
  logic              is_halt;

`ifdef SINGLE_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif

  assign is_halt = (pmem_rdata == HALT_WORD);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= FS_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_IDLE:   if (start) state_d = FS_ISSUE;
      FS_ISSUE:  if (go) state_d = FS_READ;
      FS_READ:   state_d = is_halt ? FS_HALTED : FS_HOLD;
      FS_HOLD:   if (instr_ready) state_d = FS_ISSUE;
      FS_HALTED: if (start) state_d = FS_ISSUE;
      default:   state_d = FS_IDLE;
    endcase
  end

  always_comb begin
    pmem_en = (state_q == FS_ISSUE) && go;
    halted  = (state_q == FS_HALTED);
    busy    = (state_q == FS_ISSUE) ||
              (state_q == FS_READ)  ||
              (state_q == FS_HOLD);
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    unique case (1'b1)
      state_q == FS_IDLE: begin
        if (jump_valid) pc_d = jump_addr;
      end
      state_q == FS_READ: begin
        if (!is_halt) begin
          instr_d = pmem_rdata;
          valid_d = 1'b1;
        end
      end
      state_q == FS_HOLD: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          pc_d = jump_valid ? jump_addr : pc_q + ADDR_W'(1);
        end
      end
      // Resume skips past the halt word unless redirected.
      state_q == FS_HALTED: begin
        if (jump_valid)  pc_d = jump_addr;
        else if (start)  pc_d = pc_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc          = pc_q;
  assign pmem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural
// synchronous-read program memory.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        jump_valid = 1'b0;
  logic [3:0]  jump_addr = '0;
  logic        pmem_en;
  logic [3:0]  pmem_addr;
  logic [15:0] pmem_rdata = '0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [3:0]  pc;
  logic        halted;
  logic        busy;

  logic [15:0] mem [16];
  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (pmem_en) pmem_rdata <= mem[pmem_addr];

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .jump_valid(jump_valid), .jump_addr(jump_addr),
`ifdef SINGLE_STEP_EN
    .step(1'b1),
`endif
    .pmem_en(pmem_en), .pmem_addr(pmem_addr),
    .pmem_rdata(pmem_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .halted(halted), .busy(busy)
  );

  // The halt word must never be presented as valid.
  always @(negedge clk) begin
    if (rst && instr_valid) begin
      nchk++;
      if (instr == 16'hFFFF) begin
        nfail++;
        $display("FAIL halt_emitted: instr=%h valid=1 required no valid halt word",
                 instr);
      end
    end
  end

  typedef struct {
    logic        st, jv;
    logic [3:0]  ja;
    logic        rdy;
    logic        en;
    logic [3:0]  pc;
    logic        v;
    logic [15:0] ins;
    logic        h, b;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic jv, logic [3:0] ja,
                              logic rdy, logic en, logic [3:0] p,
                              logic v, logic [15:0] ins,
                              logic h, logic b);
    vec_t r;
    r.st = st; r.jv = jv; r.ja = ja; r.rdy = rdy;
    r.en = en; r.pc = p; r.v = v; r.ins = ins;
    r.h = h; r.b = b;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic st, logic jv, logic [3:0] ja, logic rdy);
    start = st; jump_valid = jv; jump_addr = ja; instr_ready = rdy;
  endtask

  task automatic chk_outs(string tag, logic en, logic [3:0] p, logic v,
                          logic [15:0] ins, logic h, logic b, logic ci);
    chk({tag, ".pmem_en"}, 32'(pmem_en), 32'(en));
    chk({tag, ".pmem_addr"}, 32'(pmem_addr), 32'(p));
    chk({tag, ".pc"}, 32'(pc), 32'(p));
    chk({tag, ".valid"}, 32'(instr_valid), 32'(v));
    chk({tag, ".halted"}, 32'(halted), 32'(h));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    if (ci) chk({tag, ".instr"}, 32'(instr), 32'(ins));
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'hFFFF;
    mem[3] = 16'hFFFF; mem[9] = 16'h9999; mem[10] = 16'hFFFF;
    mem[11] = 16'hBBBB;

    //      st jv ja    rdy  en pc    v ins       h b
    tbl.push_back(mk(1, 0, 4'd0, 1, 1, 4'd0,  0, 16'h0,    0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd0,  0, 16'h0,    0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd0,  1, 16'h1111, 0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 1, 1, 4'd1,  0, 16'h0,    0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd1,  0, 16'h0,    0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd1,  1, 16'h2222, 0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 1, 1, 4'd2,  0, 16'h0,    0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd2,  0, 16'h0,    0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd2,  0, 16'h0,    1, 0));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd2,  0, 16'h0,    1, 0));
    tbl.push_back(mk(1, 0, 4'd0, 1, 1, 4'd3,  0, 16'h0,    0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd3,  0, 16'h0,    0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd3,  0, 16'h0,    1, 0));
    tbl.push_back(mk(1, 1, 4'd0, 1, 1, 4'd0,  0, 16'h0,    0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd0,  0, 16'h0,    0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 0, 0, 4'd0,  1, 16'h1111, 0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 0, 0, 4'd0,  1, 16'h1111, 0, 1));
    tbl.push_back(mk(0, 1, 4'd5, 0, 0, 4'd0,  1, 16'h1111, 0, 1));
    tbl.push_back(mk(1, 0, 4'd0, 0, 0, 4'd0,  1, 16'h1111, 0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 0, 0, 4'd0,  1, 16'h1111, 0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 0, 0, 4'd0,  1, 16'h1111, 0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 1, 1, 4'd1,  0, 16'h0,    0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd1,  0, 16'h0,    0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd1,  1, 16'h2222, 0, 1));
    tbl.push_back(mk(0, 1, 4'd9, 1, 1, 4'd9,  0, 16'h0,    0, 1));
    tbl.push_back(mk(1, 1, 4'd3, 1, 0, 4'd9,  0, 16'h0,    0, 1));
    tbl.push_back(mk(0, 1, 4'd4, 0, 0, 4'd9,  1, 16'h9999, 0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 1, 1, 4'd10, 0, 16'h0,    0, 1));
    tbl.push_back(mk(1, 0, 4'd0, 1, 0, 4'd10, 0, 16'h0,    0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 1, 0, 4'd10, 0, 16'h0,    1, 0));

    rst = 1'b0;
    tick(); tick();
    chk_outs("reset", 0, 4'd0, 0, 16'h0, 0, 0, 1);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].st, tbl[i].jv, tbl[i].ja, tbl[i].rdy);
      tick();
      chk_outs($sformatf("vec%0d", i), tbl[i].en, tbl[i].pc, tbl[i].v,
               tbl[i].ins, tbl[i].h, tbl[i].b, tbl[i].v);
    end

    // Reset dropped while an instruction is held.
    drive(1, 0, 4'd0, 0);
    tick();
    chk_outs("resume11", 1, 4'd11, 0, 16'h0, 0, 1, 0);
    drive(0, 0, 4'd0, 0);
    tick(); tick();
    chk_outs("hold11", 0, 4'd11, 1, 16'hBBBB, 0, 1, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_outs("rst_hold", 0, 4'd0, 0, 16'h0, 0, 0, 1);
    drive(1, 0, 4'd0, 1);
    tick();
    chk_outs("restart", 1, 4'd0, 0, 16'h0, 0, 1, 0);
    drive(0, 0, 4'd0, 1);
    tick(); tick();
    chk_outs("restart_hold", 0, 4'd0, 1, 16'h1111, 0, 1, 1);

    // IDLE redirect, then start with a same-cycle jump, then wrap.
    rst = 1'b0;
    drive(0, 0, 4'd0, 1);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 16'hA000 + 16'(i);
    drive(0, 1, 4'd5, 1);
    tick();
    chk_outs("idle_jump", 0, 4'd5, 0, 16'h0, 0, 0, 0);
    drive(1, 1, 4'd0, 1);
    tick();
    chk_outs("start_jump", 1, 4'd0, 0, 16'h0, 0, 1, 0);
    drive(0, 0, 4'd0, 1);
    for (int k = 0; k < 17; k++) begin
      cnt = 0;
      while (!instr_valid && cnt < 8) begin
        tick();
        cnt++;
      end
      if (!instr_valid) begin
        nchk++;
        nfail++;
        $display("FAIL wrap_timeout: fetch %0d got no valid within 8 cycles", k);
        break;
      end
      chk($sformatf("wrap%0d.instr", k), 32'(instr),
          32'(16'hA000 + 16'(k % 16)));
      chk($sformatf("wrap%0d.pc", k), 32'(pc), 32'(k % 16));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
